// File: rtl/out_alu_control_unit_pkg.sv
// Shared constants for the FIFO_OUT-side control unit.
// Op tags match the FIFO_IN ctrl encoding.
package out_alu_control_unit_pkg;

    localparam int DATA_SIZE      = 16;
    localparam int ID_SIZE        = 8;
    localparam int OPERATION_SIZE = 2;
    localparam int CNT_W          = 16;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // FIFO_OUT word layout: {result, id, op}, op in the low bits
    localparam int OP_LSB  = 0;
    localparam int ID_LSB  = OPERATION_SIZE;
    localparam int RES_LSB = OPERATION_SIZE + ID_SIZE;

    typedef enum logic {
        CH_ADD = 1'b0,
        CH_MUL = 1'b1
    } channel_e;

endpackage

// File: rtl/d_ff_async_en.sv
// Enabled register bank with asynchronous active-high reset to zero.
module d_ff_async_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/out_result_hold.sv
// One-entry result hold register with valid/ready capture and
// clear-on-grant; ready is purely registered.
module out_result_hold #(
    parameter int DATA_SIZE = 16,
    parameter int ID_SIZE   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_result,
    input  logic [ID_SIZE-1:0]   i_id,
    output logic                 o_ready,
    input  logic                 i_clear,
    output logic                 o_hold_valid,
    output logic [DATA_SIZE-1:0] o_result,
    output logic [ID_SIZE-1:0]   o_id
);

    logic r_valid;
    logic w_load;

    assign w_load = i_valid & ~r_valid;

    // Clear and load never coincide: a granted hold is occupied,
    // so it cannot be loading in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end
    end

    d_ff_async_en #(
        .W (DATA_SIZE)
    ) u_res_ff (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_load),
        .i_d  (i_result),
        .o_q  (o_result)
    );

    d_ff_async_en #(
        .W (ID_SIZE)
    ) u_id_ff (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_load),
        .i_d  (i_id),
        .o_q  (o_id)
    );

    assign o_ready      = ~r_valid;
    assign o_hold_valid = r_valid;

endmodule

// File: rtl/out_alu_control_unit.sv
// Collects adder/multiplier results and writes tagged words into
// FIFO_OUT with round-robin arbitration and back-pressure.
module out_alu_control_unit
    import out_alu_control_unit_pkg::*;
#(
    parameter int DATA_SIZE      = out_alu_control_unit_pkg::DATA_SIZE,
    parameter int ID_SIZE        = out_alu_control_unit_pkg::ID_SIZE,
    parameter int OPERATION_SIZE = out_alu_control_unit_pkg::OPERATION_SIZE,
    parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE,
    parameter int CNT_W          = out_alu_control_unit_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid_res,
    input  logic [DATA_SIZE-1:0]      a_result,
    input  logic [ID_SIZE-1:0]        a_id,
    output logic                      a_ready_res,
    input  logic                      m_valid_res,
    input  logic [DATA_SIZE-1:0]      m_result,
    input  logic [ID_SIZE-1:0]        m_id,
    output logic                      m_ready_res,
    input  logic                      full_out,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] w_data_out,
    output logic [CNT_W-1:0]          wr_count,
    output logic                      busy
);

    logic                      w_a_hold_valid;
    logic                      w_m_hold_valid;
    logic [DATA_SIZE-1:0]      w_a_hold_res;
    logic [DATA_SIZE-1:0]      w_m_hold_res;
    logic [ID_SIZE-1:0]        w_a_hold_id;
    logic [ID_SIZE-1:0]        w_m_hold_id;
    logic                      w_grant_a;
    logic                      w_grant_m;
    logic [DATA_SIZE-1:0]      w_sel_res;
    logic [ID_SIZE-1:0]        w_sel_id;
    logic [OPERATION_SIZE-1:0] w_sel_op;
    channel_e                  r_last_grant;
    logic [CNT_W-1:0]          r_wr_count;

    out_result_hold #(
        .DATA_SIZE (DATA_SIZE),
        .ID_SIZE   (ID_SIZE)
    ) u_add_hold (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (a_valid_res),
        .i_result     (a_result),
        .i_id         (a_id),
        .o_ready      (a_ready_res),
        .i_clear      (w_grant_a),
        .o_hold_valid (w_a_hold_valid),
        .o_result     (w_a_hold_res),
        .o_id         (w_a_hold_id)
    );

    out_result_hold #(
        .DATA_SIZE (DATA_SIZE),
        .ID_SIZE   (ID_SIZE)
    ) u_mul_hold (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (m_valid_res),
        .i_result     (m_result),
        .i_id         (m_id),
        .o_ready      (m_ready_res),
        .i_clear      (w_grant_m),
        .o_hold_valid (w_m_hold_valid),
        .o_result     (w_m_hold_res),
        .o_id         (w_m_hold_id)
    );

    // The channel that did not win last time has priority on a tie
    assign w_grant_a = w_a_hold_valid & ~full_out &
                       (~w_m_hold_valid | (r_last_grant == CH_MUL));
    assign w_grant_m = w_m_hold_valid & ~full_out &
                       (~w_a_hold_valid | (r_last_grant == CH_ADD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= CH_MUL;
        end else if (w_grant_a) begin
            r_last_grant <= CH_ADD;
        end else if (w_grant_m) begin
            r_last_grant <= CH_MUL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_grant_a | w_grant_m) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    // Idle output carries ADD hold contents with a zero op tag
    always_comb begin
        w_sel_res = w_a_hold_res;
        w_sel_id  = w_a_hold_id;
        w_sel_op  = '0;
        if (w_grant_m) begin
            w_sel_res = w_m_hold_res;
            w_sel_id  = w_m_hold_id;
            w_sel_op  = OPERATION_SIZE'(OP_MUL);
        end else if (w_grant_a) begin
            w_sel_op  = OPERATION_SIZE'(OP_ADD);
        end
    end

    assign w_en_out   = w_grant_a | w_grant_m;
    assign w_data_out = FIFO_OUT_WIDTH'({w_sel_res, w_sel_id, w_sel_op});
    assign wr_count   = r_wr_count;
    assign busy       = w_a_hold_valid | w_m_hold_valid;

endmodule

// File: tb/tb_out_alu_control_unit.sv
// Self-checking bench: directed table, reset/wrap/fairness sequences
// and randomized traffic against a queue-level reference model.
module tb_out_alu_control_unit;
    import out_alu_control_unit_pkg::*;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b0;
    logic        a_valid_res = 1'b0;
    logic [15:0] a_result = '0;
    logic [7:0]  a_id = '0;
    logic        m_valid_res = 1'b0;
    logic [15:0] m_result = '0;
    logic [7:0]  m_id = '0;
    logic        full_out = 1'b0;

    logic        a_ready_res, m_ready_res, w_en_out, busy;
    logic [25:0] w_data_out;
    logic [15:0] wr_count;
    logic        a_ready4, m_ready4, w_en4, busy4;
    logic [25:0] w_data4;
    logic [3:0]  wr_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = clk_en ? ~clk : clk;

    out_alu_control_unit dut (
        .clk(clk), .rst(rst),
        .a_valid_res(a_valid_res), .a_result(a_result), .a_id(a_id),
        .a_ready_res(a_ready_res),
        .m_valid_res(m_valid_res), .m_result(m_result), .m_id(m_id),
        .m_ready_res(m_ready_res),
        .full_out(full_out), .w_en_out(w_en_out), .w_data_out(w_data_out),
        .wr_count(wr_count), .busy(busy)
    );

    out_alu_control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .a_valid_res(a_valid_res), .a_result(a_result), .a_id(a_id),
        .a_ready_res(a_ready4),
        .m_valid_res(m_valid_res), .m_result(m_result), .m_id(m_id),
        .m_ready_res(m_ready4),
        .full_out(full_out), .w_en_out(w_en4), .w_data_out(w_data4),
        .wr_count(wr_count4), .busy(busy4)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] mk(input logic [15:0] r,
                                       input logic [7:0] i,
                                       input logic [1:0] op);
        return {r, i, op};
    endfunction

    typedef struct {
        logic        rst;
        logic        av;
        logic [15:0] ar;
        logic [7:0]  ai;
        logic        mv;
        logic [15:0] mr;
        logic [7:0]  mi;
        logic        full;
        logic        ew;
        logic        cd;
        logic [25:0] ed;
        logic        ear;
        logic        emr;
        logic        eb;
        logic [15:0] ec;
    } vec_t;

    function automatic vec_t row(
        input logic r, input logic av, input logic [15:0] ar,
        input logic [7:0] ai, input logic mv, input logic [15:0] mr,
        input logic [7:0] mi, input logic full, input logic ew,
        input logic cd, input logic [25:0] ed, input logic ear,
        input logic emr, input logic eb, input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.av = av; v.ar = ar; v.ai = ai;
        v.mv = mv; v.mr = mr; v.mi = mi; v.full = full;
        v.ew = ew; v.cd = cd; v.ed = ed;
        v.ear = ear; v.emr = emr; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    // Reference model state (channel 0 = ADD, 1 = MUL)
    logic        hv[2];
    logic [25:0] hw[2];
    logic        pres[2];
    logic [25:0] pw[2];
    int          last;
    int          cnt;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hv[c] = 1'b0;
            pres[c] = 1'b0;
        end
        last = 1;
        cnt = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    vec_t vt[16];

    initial begin
        int a_k, m_k, a_exp, m_exp, writes, viol, prev, idmis;
        logic acc_a, acc_m;
        logic [1:0] op;

        // Directed table
        vt[0]  = row(1,1,16'h0005,8'h3C,0,0,0,0, 0,1,0,1,1,0,0);
        vt[1]  = row(0,0,0,0,0,0,0,0, 1,1,mk(16'h0005,8'h3C,2'b01),0,1,1,0);
        vt[2]  = row(0,0,0,0,0,0,0,0, 0,0,0,1,1,0,1);
        vt[3]  = row(1,1,16'h1111,8'h01,1,16'h00E1,8'h02,0, 0,1,0,1,1,0,0);
        vt[4]  = row(0,0,0,0,0,0,0,0, 1,1,mk(16'h1111,8'h01,2'b01),0,0,1,0);
        vt[5]  = row(0,0,0,0,0,0,0,0, 1,1,mk(16'h00E1,8'h02,2'b10),1,0,1,1);
        vt[6]  = row(0,0,0,0,0,0,0,0, 0,0,0,1,1,0,2);
        vt[7]  = row(0,1,16'hABCD,8'h10,1,16'h1234,8'h20,1, 0,0,0,1,1,0,2);
        for (int i = 8; i < 13; i++)
            vt[i] = row(0,1,16'hFFFF,8'hEE,1,16'hEEEE,8'hDD,1, 0,0,0,0,0,1,2);
        vt[13] = row(0,0,0,0,0,0,0,0, 1,1,mk(16'hABCD,8'h10,2'b01),0,0,1,2);
        vt[14] = row(0,0,0,0,0,0,0,0, 1,1,mk(16'h1234,8'h20,2'b10),1,0,1,3);
        vt[15] = row(0,0,0,0,0,0,0,0, 0,0,0,1,1,0,4);

        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (vt[i].rst) pulse_reset();
            a_valid_res = vt[i].av; a_result = vt[i].ar; a_id = vt[i].ai;
            m_valid_res = vt[i].mv; m_result = vt[i].mr; m_id = vt[i].mi;
            full_out = vt[i].full;
            #1;
            chk($sformatf("tbl%0d_wen", i), 64'(w_en_out), 64'(vt[i].ew));
            if (vt[i].cd)
                chk($sformatf("tbl%0d_data", i), 64'(w_data_out), 64'(vt[i].ed));
            chk($sformatf("tbl%0d_ardy", i), 64'(a_ready_res), 64'(vt[i].ear));
            chk($sformatf("tbl%0d_mrdy", i), 64'(m_ready_res), 64'(vt[i].emr));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(vt[i].eb));
            chk($sformatf("tbl%0d_cnt", i), 64'(wr_count), 64'(vt[i].ec));
        end

        // Asynchronous reset with the clock stopped and holds loaded
        @(negedge clk);
        a_valid_res = 1; a_result = 16'h7777; a_id = 8'h77;
        m_valid_res = 1; m_result = 16'h8888; m_id = 8'h88;
        full_out = 0;
        @(negedge clk);
        a_valid_res = 0; m_valid_res = 0;
        clk_en = 1'b0;
        #1;
        chk("arst_pre_wen", 64'(w_en_out), 64'(1));
        chk("arst_pre_cnt", 64'(wr_count), 64'(4));
        rst = 1'b1;
        #3;
        chk("arst_wen", 64'(w_en_out), 64'(0));
        chk("arst_cnt", 64'(wr_count), 64'(0));
        chk("arst_ardy", 64'(a_ready_res), 64'(1));
        chk("arst_mrdy", 64'(m_ready_res), 64'(1));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_data", 64'(w_data_out), 64'(0));
        #10;
        rst = 1'b0;
        clk_en = 1'b1;

        // Counter wrap: 17 single ADD writes
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_valid_res = 1; a_result = 16'(i); a_id = 8'(i);
            @(negedge clk);
            a_valid_res = 0;
        end
        @(negedge clk);
        #1;
        chk("wrap_cnt16", 64'(wr_count), 64'(17));
        chk("wrap_cnt4", 64'(wr_count4), 64'(1));

        // Fairness: continuous streams on both channels
        @(negedge clk);
        pulse_reset();
        a_k = 0; m_k = 0; a_exp = 0; m_exp = 0;
        writes = 0; viol = 0; prev = -1; idmis = 0;
        acc_a = 0; acc_m = 0;
        for (int cyc = 0; cyc < 400 && writes < 100; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (acc_a) a_k++;
            if (acc_m) m_k++;
            a_valid_res = 1; a_result = 16'h1000 + 16'(a_k); a_id = 8'(a_k);
            m_valid_res = 1; m_result = 16'h2000 + 16'(m_k); m_id = 8'(m_k);
            #1;
            acc_a = a_ready_res;
            acc_m = m_ready_res;
            if (w_en_out) begin
                op = w_data_out[OP_LSB +: 2];
                if (writes > 0 && int'(op) == prev) viol++;
                prev = int'(op);
                if (op == OP_ADD) begin
                    if (w_data_out[ID_LSB +: 8] != 8'(a_exp) ||
                        w_data_out[RES_LSB +: 16] != 16'h1000 + 16'(a_exp))
                        idmis++;
                    a_exp++;
                end else begin
                    if (w_data_out[ID_LSB +: 8] != 8'(m_exp) ||
                        w_data_out[RES_LSB +: 16] != 16'h2000 + 16'(m_exp))
                        idmis++;
                    m_exp++;
                end
                writes++;
            end
        end
        chk("fair_writes", 64'(writes), 64'(100));
        chk("fair_alternation", 64'(viol), 64'(0));
        chk("fair_order", 64'(idmis), 64'(0));
        chk("fair_add_share", 64'(a_exp), 64'(50));

        // Randomized traffic against the reference model
        @(negedge clk);
        a_valid_res = 0; m_valid_res = 0;
        pulse_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int win;
            logic old_hv[2];
            logic [25:0] exp_d;
            if (cyc != 0) @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
                model_reset();
            end
            for (int c = 0; c < 2; c++) begin
                if (!pres[c] && $urandom_range(0, 99) < 55) begin
                    pres[c] = 1'b1;
                    pw[c] = {16'($urandom), 8'($urandom),
                             (c == 0) ? OP_ADD : OP_MUL};
                end
            end
            a_valid_res = pres[0];
            a_result = pres[0] ? pw[0][25:10] : 16'($urandom);
            a_id = pres[0] ? pw[0][9:2] : 8'($urandom);
            m_valid_res = pres[1];
            m_result = pres[1] ? pw[1][25:10] : 16'($urandom);
            m_id = pres[1] ? pw[1][9:2] : 8'($urandom);
            full_out = ($urandom_range(0, 99) < 25);
            #1;
            win = -1;
            if (!full_out) begin
                if (hv[0] && hv[1]) win = (last == 0) ? 1 : 0;
                else if (hv[0]) win = 0;
                else if (hv[1]) win = 1;
            end
            exp_d = (win >= 0) ? hw[win] : '0;
            chk("rnd_wen", 64'(w_en_out), 64'(win >= 0));
            if (win >= 0) chk("rnd_data", 64'(w_data_out), 64'(exp_d));
            chk("rnd_ardy", 64'(a_ready_res), 64'(!hv[0]));
            chk("rnd_mrdy", 64'(m_ready_res), 64'(!hv[1]));
            chk("rnd_busy", 64'(busy), 64'(hv[0] || hv[1]));
            chk("rnd_cnt", 64'(wr_count), 64'(cnt % 65536));
            chk("rnd_cnt4", 64'(wr_count4), 64'(cnt % 16));
            old_hv[0] = hv[0];
            old_hv[1] = hv[1];
            if (win >= 0) begin
                hv[win] = 1'b0;
                last = win;
                cnt++;
            end
            for (int c = 0; c < 2; c++) begin
                if (pres[c] && !old_hv[c]) begin
                    hv[c] = 1'b1;
                    hw[c] = pw[c];
                    pres[c] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
